// File: rtl/mtr_drv_slew.sv
// Multi-channel complementary PWM motor driver with deadtime, target clamping
// and per-period duty slew limiting. All channels share one free-running counter.
module mtr_drv_slew #(
    parameter int unsigned W    = 11,
    parameter int unsigned NCH  = 2,
    parameter int unsigned DEAD = 16,
    parameter int unsigned SLEW = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [NCH*W-1:0] spd,
    output logic [NCH-1:0]   PWM1,
    output logic [NCH-1:0]   PWM2,
    output logic [NCH-1:0]   sat,
    output logic             prd_start
);

    typedef logic signed [W+1:0] ext_t;

    localparam logic [W-1:0] CntMax = {W{1'b1}};
    localparam logic [W-1:0] Mid    = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] DeadW  = W'(DEAD);
    localparam logic [W:0]   DeadE  = (W+1)'(DEAD);
    localparam logic [W-1:0] SlewW  = W'(SLEW);
    localparam ext_t         TgtLo  = ext_t'(DEAD);
    localparam ext_t         TgtHi  = ext_t'((2 ** W) - 1 - DEAD);
    localparam ext_t         SlewE  = ext_t'(SLEW);
    localparam ext_t         MidE   = ext_t'(2 ** (W - 1));

    logic [W-1:0]          cnt_q, cnt_d;
    logic [NCH-1:0][W-1:0] duty_q, duty_d;
    logic [NCH-1:0]        pwm1_q, pwm1_d;
    logic [NCH-1:0]        pwm2_q, pwm2_d;
    logic [NCH-1:0]        sat_q, sat_d;
    logic                  run_q, run_d;
    logic                  prd_q, prd_d;

    always_comb begin
        logic [W-1:0] spd_k;
        logic [W-1:0] duty_nxt;
        ext_t         tgt_raw;
        ext_t         tgt_clp;
        ext_t         diff;
        logic         clip;
        logic         period_end;
        logic         set1, clr1, set2, clr2;

        cnt_d      = cnt_q + W'(1);
        prd_d      = (cnt_d == '0);
        period_end = (cnt_q == CntMax);
        // Low-side turn-on is only allowed once a full high-side phase has started
        // under enable, so re-enabling mid-period cannot emit a stray PWM2 pulse.
        run_d      = en & (run_q | (cnt_q == DeadW));

        for (int k = 0; k < int'(NCH); k++) begin
            spd_k   = spd[k*W +: W];
            tgt_raw = $signed({{2{spd_k[W-1]}}, spd_k}) + MidE;
            tgt_clp = tgt_raw;
            clip    = 1'b0;
            if (tgt_raw < TgtLo) begin
                tgt_clp = TgtLo;
                clip    = 1'b1;
            end else if (tgt_raw > TgtHi) begin
                tgt_clp = TgtHi;
                clip    = 1'b1;
            end

            diff = tgt_clp - $signed({2'b00, duty_q[k]});
            if (diff > SlewE) begin
                duty_nxt = duty_q[k] + SlewW;
            end else if (diff < -SlewE) begin
                duty_nxt = duty_q[k] - SlewW;
            end else begin
                duty_nxt = tgt_clp[W-1:0];
            end

            duty_d[k] = duty_q[k];
            if (!en) begin
                duty_d[k] = Mid;
            end else if (period_end) begin
                duty_d[k] = duty_nxt;
            end
            sat_d[k] = period_end ? clip : sat_q[k];

            // Clear has priority over set on the same count.
            set1 = (cnt_q == DeadW);
            clr1 = (cnt_q == duty_q[k]);
            set2 = run_q && ({1'b0, cnt_q} == ({1'b0, duty_q[k]} + DeadE));
            clr2 = period_end;

            pwm1_d[k] = en && !clr1 && (set1 || pwm1_q[k]);
            pwm2_d[k] = en && !clr2 && (set2 || pwm2_q[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            duty_q <= {NCH{Mid}};
            pwm1_q <= '0;
            pwm2_q <= '0;
            sat_q  <= '0;
            run_q  <= 1'b0;
            prd_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            duty_q <= duty_d;
            pwm1_q <= pwm1_d;
            pwm2_q <= pwm2_d;
            sat_q  <= sat_d;
            run_q  <= run_d;
            prd_q  <= prd_d;
        end
    end

    assign PWM1      = pwm1_q;
    assign PWM2      = pwm2_q;
    assign sat       = sat_q;
    assign prd_start = prd_q;

endmodule

// File: tb/tb_mtr_drv_slew.sv
// Self-checking bench for mtr_drv_slew, run at a reduced counter width so that
// long slew sequences and a randomised run fit in a short simulation.
module tb_mtr_drv_slew;

    localparam int W    = 8;
    localparam int NCH  = 2;
    localparam int DEAD = 8;
    localparam int SLEW = 8;
    localparam int PER  = 1 << W;
    localparam int MID  = 1 << (W - 1);
    localparam int HI   = PER - 1 - DEAD;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic             en    = 1'b0;
    logic [NCH*W-1:0] spd   = '0;
    logic [NCH-1:0]   pwm1, pwm2, sat;
    logic             prd_start;

    mtr_drv_slew #(
        .W   (W),
        .NCH (NCH),
        .DEAD(DEAD),
        .SLEW(SLEW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .spd      (spd),
        .PWM1     (pwm1),
        .PWM2     (pwm2),
        .sat      (sat),
        .prd_start(prd_start)
    );

    always #5 clk = ~clk;

    // Reference period counter, reset the same way the specified counter is.
    int tcnt = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tcnt <= 0;
        else        tcnt <= (tcnt + 1) % PER;
    end

    typedef struct packed {
        logic                  e;
        logic                  fresh;
        logic [NCH-1:0][15:0]  duty;
        logic [NCH-1:0]        s;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   mdl_duty[NCH];
    logic mdl_sat[NCH];
    int   spd_v[NCH];
    logic en_v  = 1'b0;
    bit   fresh = 1'b0;
    int   m_f1[NCH], m_l1[NCH], m_n1[NCH];
    int   m_f2[NCH], m_l2[NCH], m_n2[NCH];
    int   m_duty[NCH];

    function automatic int tgt_of(int s);
        int t;
        t = s + MID;
        if (t < DEAD) t = DEAD;
        if (t > HI)   t = HI;
        return t;
    endfunction

    function automatic logic clip_of(int s);
        return (s + MID < DEAD) || (s + MID > HI);
    endfunction

    function automatic int slew_to(int d, int t);
        if (t > d + SLEW) return d + SLEW;
        if (t < d - SLEW) return d - SLEW;
        return t;
    endfunction

    task automatic drive_spd();
        for (int k = 0; k < NCH; k++) spd[k*W +: W] = W'(spd_v[k]);
    endtask

    // Period-end update as the bench expects it, using the inputs present then.
    task automatic model_end();
        for (int k = 0; k < NCH; k++) begin
            mdl_sat[k]  = clip_of(spd_v[k]);
            mdl_duty[k] = en_v ? slew_to(mdl_duty[k], tgt_of(spd_v[k])) : MID;
        end
    endtask

    task automatic reset_model();
        fresh = 1'b1;
        for (int k = 0; k < NCH; k++) begin
            mdl_duty[k] = MID;
            mdl_sat[k]  = 1'b0;
        end
    endtask

    // One full period: drive at cnt 0, push the expectation, measure, pop and compare.
    task automatic run_period(input logic e, input int s0, input int s1);
        exp_t           x;
        int             d, ef1, el1, en1, ef2, el2, en2, prd_bad, ovl;
        logic [NCH-1:0] sat_mid;
        while (tcnt != 0) @(negedge clk);
        en = e; en_v = e; spd_v[0] = s0; spd_v[1] = s1;
        drive_spd();
        x.e = e;
        x.fresh = fresh;
        for (int k = 0; k < NCH; k++) begin
            x.duty[k] = 16'(mdl_duty[k]);
            x.s[k]    = mdl_sat[k];
        end
        sb.push_back(x);
        fresh = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            m_f1[k] = -1; m_l1[k] = -1; m_n1[k] = 0;
            m_f2[k] = -1; m_l2[k] = -1; m_n2[k] = 0;
        end
        prd_bad = 0; ovl = 0; sat_mid = '0;
        for (int i = 0; i < PER; i++) begin
            if (prd_start !== ((i == 0) && !x.fresh)) prd_bad++;
            if ((pwm1 & pwm2) !== '0) ovl++;
            for (int k = 0; k < NCH; k++) begin
                if (pwm1[k] === 1'b1) begin
                    if (m_f1[k] < 0) m_f1[k] = i;
                    m_l1[k] = i; m_n1[k]++;
                end
                if (pwm2[k] === 1'b1) begin
                    if (m_f2[k] < 0) m_f2[k] = i;
                    m_l2[k] = i; m_n2[k]++;
                end
            end
            if (i == PER / 2) sat_mid = sat;
            @(negedge clk);
        end
        model_end();
        x = sb.pop_front();
        checks++;
        if (prd_bad != 0) begin
            errors++;
            $display("FAIL prd_start: %0d wrong cycles in period, want 0", prd_bad);
        end
        checks++;
        if (ovl != 0) begin
            errors++;
            $display("FAIL overlap: PWM1&PWM2 high in %0d cycles, want 0", ovl);
        end
        for (int k = 0; k < NCH; k++) begin
            d = int'(x.duty[k]);
            ef1 = -1; el1 = -1; ef2 = -1; el2 = -1;
            if (x.e) begin
                if (d > DEAD) begin ef1 = DEAD + 1; el1 = d; end
                if (d + DEAD < PER - 1) begin ef2 = d + DEAD + 1; el2 = PER - 1; end
            end
            en1 = (ef1 < 0) ? 0 : el1 - ef1 + 1;
            en2 = (ef2 < 0) ? 0 : el2 - ef2 + 1;
            checks++;
            if (m_f1[k] != ef1 || m_l1[k] != el1 || m_n1[k] != en1) begin
                errors++;
                $display("FAIL pwm1_ch%0d: got first=%0d last=%0d n=%0d, want %0d/%0d/%0d",
                         k, m_f1[k], m_l1[k], m_n1[k], ef1, el1, en1);
            end
            checks++;
            if (m_f2[k] != ef2 || m_l2[k] != el2 || m_n2[k] != en2) begin
                errors++;
                $display("FAIL pwm2_ch%0d: got first=%0d last=%0d n=%0d, want %0d/%0d/%0d",
                         k, m_f2[k], m_l2[k], m_n2[k], ef2, el2, en2);
            end
            checks++;
            if (sat_mid[k] !== x.s[k]) begin
                errors++;
                $display("FAIL sat_ch%0d: got %b, want %b", k, sat_mid[k], x.s[k]);
            end
            m_duty[k] = (m_n2[k] > 0) ? m_f2[k] - DEAD - 1 : m_l1[k];
        end
    endtask

    task automatic test_reset();
        en = 1'b1; en_v = 1'b1; spd_v = '{0, 0};
        drive_spd();
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (pwm1 !== '0 || pwm2 !== '0) begin
            errors++;
            $display("FAIL reset_pwm: got %b/%b, want 00/00", pwm1, pwm2);
        end
        checks++;
        if (sat !== '0 || prd_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got sat=%b prd=%b, want 00/0", sat, prd_start);
        end
        rst_n = 1'b1;
        reset_model();
    endtask

    task automatic test_nominal();
        for (int p = 0; p < 3; p++) begin
            run_period(1'b1, 0, 0);
            checks++;
            if (m_n1[0] != MID - DEAD || m_n2[0] != PER - 1 - MID - DEAD) begin
                errors++;
                $display("FAIL nominal_width: got n1=%0d n2=%0d, want %0d/%0d",
                         m_n1[0], m_n2[0], MID - DEAD, PER - 1 - MID - DEAD);
            end
        end
    endtask

    task automatic test_ramp();
        for (int p = 0; p < 12; p++) begin
            run_period(1'b1, 80, 0);
            if (p == 9 || p == 10) begin
                checks++;
                if (m_duty[0] != ((p == 9) ? MID + 72 : MID + 80) || m_duty[1] != MID) begin
                    errors++;
                    $display("FAIL ramp_p%0d: got duty=%0d/%0d, want %0d/%0d", p, m_duty[0],
                             m_duty[1], (p == 9) ? MID + 72 : MID + 80, MID);
                end
            end
        end
    endtask

    task automatic test_saturation();
        for (int p = 0; p < 16; p++) run_period(1'b1, 127, 0);
        checks++;
        if (m_duty[0] != HI || m_n2[0] != 0 || sat[0] !== 1'b1) begin
            errors++;
            $display("FAIL sat_high: got duty=%0d n2=%0d sat=%b, want %0d/0/1",
                     m_duty[0], m_n2[0], sat[0], HI);
        end
        for (int p = 0; p < 32; p++) run_period(1'b1, -128, 0);
        checks++;
        if (m_duty[0] != DEAD || m_n1[0] != 0 || sat[0] !== 1'b1) begin
            errors++;
            $display("FAIL sat_low: got duty=%0d n1=%0d sat=%b, want %0d/0/1",
                     m_duty[0], m_n1[0], sat[0], DEAD);
        end
    endtask

    task automatic test_enable();
        int   hi_cnt;
        logic pre;
        while (tcnt != 0) @(negedge clk);
        en = 1'b1; en_v = 1'b1; spd_v = '{0, 0};
        drive_spd();
        hi_cnt = 0; pre = 1'b0;
        for (int i = 0; i < PER; i++) begin
            if (i > 100 && (pwm1 !== '0 || pwm2 !== '0)) hi_cnt++;
            if (i == 100) begin
                pre = pwm2[0];
                en = 1'b0; en_v = 1'b0;
            end
            @(negedge clk);
        end
        model_end();
        checks++;
        if (pre !== 1'b1 || hi_cnt != 0) begin
            errors++;
            $display("FAIL en_drop: got pre=%b high_after=%0d, want 1/0", pre, hi_cnt);
        end
        run_period(1'b0, 0, 0);
        hi_cnt = 0;
        for (int i = 0; i < PER; i++) begin
            if (pwm1 !== '0 || pwm2 !== '0) hi_cnt++;
            if (i == 100) begin
                en = 1'b1; en_v = 1'b1; spd_v[0] = -64;
                drive_spd();
            end
            @(negedge clk);
        end
        model_end();
        checks++;
        if (hi_cnt != 0) begin
            errors++;
            $display("FAIL en_restore_quiet: got %0d high cycles, want 0", hi_cnt);
        end
        for (int p = 0; p < 8; p++) begin
            run_period(1'b1, -64, 0);
            if (p == 0 || p == 7) begin
                checks++;
                if (m_duty[0] != ((p == 0) ? MID - SLEW : MID - 64)) begin
                    errors++;
                    $display("FAIL en_slew_p%0d: got duty=%0d, want %0d", p, m_duty[0],
                             (p == 0) ? MID - SLEW : MID - 64);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic pre;
        while (tcnt != 0) @(negedge clk);
        repeat (40) @(negedge clk);
        pre = pwm1[0];
        rst_n = 1'b0;
        #1;
        checks++;
        if (pre !== 1'b1 || pwm1 !== '0 || pwm2 !== '0) begin
            errors++;
            $display("FAIL reset_async: got pre=%b pwm1=%b pwm2=%b, want 1/00/00", pre, pwm1,
                     pwm2);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        reset_model();
        run_period(1'b1, -64, 0);
        checks++;
        if (m_f1[0] != DEAD + 1 || m_duty[0] != MID) begin
            errors++;
            $display("FAIL reset_restart: got first=%0d duty=%0d, want %0d/%0d", m_f1[0],
                     m_duty[0], DEAD + 1, MID);
        end
    endtask

    task automatic test_random();
        int   prev[NCH];
        logic prev_e;
        logic e;
        int   s0, s1, delta;
        prev_e = 1'b0;
        for (int n = 0; n < 100; n++) begin
            e  = ($urandom_range(0, 7) != 0);
            s0 = int'($urandom_range(0, PER - 1)) - MID;
            s1 = int'($urandom_range(0, PER - 1)) - MID;
            run_period(e, s0, s1);
            if (e && prev_e) begin
                for (int k = 0; k < NCH; k++) begin
                    delta = m_duty[k] - prev[k];
                    if (delta < 0) delta = -delta;
                    checks++;
                    if (delta > SLEW) begin
                        errors++;
                        $display("FAIL random_slew_ch%0d: got step=%0d, want <= %0d", k, delta,
                                 SLEW);
                    end
                end
            end
            prev   = m_duty;
            prev_e = e;
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_ramp();
        test_saturation();
        test_enable();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mtr_drv_slew.md
MTR_DRV_SLEW -- requirements
Module: mtr_drv_slew

Interface
REQ-001 Parameter W, default 11: speed and PWM counter width; PWM period = 2^W clocks.
REQ-002 Parameter NCH, default 2: number of independent motor channels.
REQ-003 Parameter DEAD, default 16: non-overlap deadtime in clocks; DEAD < 2^(W-2).
REQ-004 Parameter SLEW, default 32: maximum duty change per channel per PWM period; SLEW >= 1.
REQ-005 clk  input  1  sole clock; all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 en  input  1  drive enable; 0 = coast, both outputs low.
REQ-008 spd  input  NCH*W  packed signed two's-complement speeds; channel k occupies bits [k*W+W-1 : k*W].
REQ-009 PWM1  output  NCH  high-side drive per channel, registered.
REQ-010 PWM2  output  NCH  complementary drive per channel, registered.
REQ-011 sat  output  NCH  per-channel saturation flag, registered.
REQ-012 prd_start  output  1  one-cycle pulse, high while cnt == 0.

Function
REQ-013 Single free-running unsigned W-bit counter cnt, shared by all channels; increments every clk; wraps 2^W-1 -> 0.
REQ-014 Target duty per channel: tgt = spd_k + 2^(W-1), computed in W+1 bits; spd = 0 maps to the midpoint 2^(W-1).
REQ-015 Clamp tgt to [DEAD, 2^W-1-DEAD].
REQ-016 sat_k is 1 when the clamp altered tgt. It is sampled at the period-end update.
REQ-017 Applied duty register duty_k updates only when cnt == 2^W-1 and takes effect from the next cnt == 0.
REQ-018 Slew rule at update: if |tgt - duty_k| <= SLEW then duty_k = tgt; else duty_k moves SLEW toward tgt.
REQ-019 spd changes within a period do not affect the current period.
REQ-020 PWM1_k is set on the clock after cnt == DEAD and cleared on the clock after cnt == duty_k; if both happen on the same cnt, clear wins.
REQ-021 PWM2_k is set on the clock after cnt == duty_k + DEAD and cleared on the clock after cnt == 2^W-1; if both happen on the same cnt, clear wins.
REQ-022 PWM1_k and PWM2_k are never high in the same cycle. Each transition between them has at least DEAD low-low clocks.
REQ-023 en = 0 forces PWM1, PWM2 low on the next clock and holds every duty_k at 2^(W-1). cnt keeps running. sat still updates.
REQ-024 On en 0->1, duty_k slews from 2^(W-1) starting at the next period-end update. No output pulse is generated before the next cnt == DEAD.
REQ-025 Channels are fully independent except for the shared cnt and en.

Reset
REQ-026 While rst_n = 0: cnt = 0, every duty_k = 2^(W-1), PWM1 = 0, PWM2 = 0, sat = 0, prd_start = 0. Outputs go low immediately, without waiting for clk.
REQ-027 After rst_n deasserts, the first clock edge begins counting from cnt = 0. A mid-period reset abandons the period with no partial pulse.

Verification (W=11, NCH=2, DEAD=16, SLEW=32)
REQ-028 Reset, en=1, spd=0 both channels:
  - PWM1 high for cnt 17..1024 (1008 clocks).
  - PWM2 high for cnt 1041..2047 (1007 clocks).
  - prd_start once per 2048 clocks.
REQ-029 Ramp on channel 0: spd0 steps 0 -> +320 at steady state.
  - duty0 = 1056, 1088, ..., 1344, reached after exactly 10 period-end updates, then constant.
  - Channel 1 stays at 1024.
REQ-030 Saturation on channel 0, allowed to settle:
  - spd0 = +1023: duty0 = 2031, sat[0] = 1; PWM2 set and clear coincide, so PWM2 stays low.
  - spd0 = -1024: duty0 = 16, sat[0] = 1; PWM1 never high.
REQ-031 Enable drop and restore:
  - en dropped at cnt = 500: both outputs low from cnt 501; duty returns to 1024.
  - en restored with spd0 = -256: duty0 = 992, 960, ..., 768 over 8 updates.
REQ-032 rst_n pulsed low at cnt = 700 with PWM1 high: PWM1 low asynchronously; cnt = 0 after release; first PWM1 high at cnt 17.
REQ-033 Random spd and en stimulus for 200 periods: check that PWM1 & PWM2 is never 1, and each duty change is <= 32 per period.
